// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request at a time, word/byte loads and stores
// into an internal array, with byte stores done as read-merge-write.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        oeram,
  input  logic        weram,
  input  logic        lwlbu,
  input  logic        swsb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request is taken on a rising edge where req_valid and
  // req_ready are both high and at least one of oeram/weram is set; each
  // taken request produces exactly one rsp_valid pulse (err qualifies it).
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    MRG  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic          lwlbu_q;
  logic          load_q;
  logic [31:0]   rd_word;
  logic [31:0]   rdata_hold;
  logic [31:0]   load_val;
  logic [31:0]   merged;
  logic [31:0]   word_num;
  logic          rejected;
  logic          req_fire;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign state_dbg = state;
  assign req_fire  = req_valid && (state == IDLE) && (oeram || weram);
  assign word_num  = {2'b00, addr[31:2]};
  assign rejected  = (oeram && weram)
                   || (oeram && !lwlbu && addr[1:0] != 2'b00)
                   || (weram && !swsb && addr[1:0] != 2'b00)
                   || (word_num >= 32'(DEPTH_WORDS));

  always_comb begin
    merged = rd_word;
    merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    load_val = lwlbu_q ? {24'b0, rd_word[{lane_q, 3'b000} +: 8]} : rd_word;
  end

  // rdata shows the fresh load result during DONE and the held value otherwise.
  assign rdata = (state == DONE && load_q) ? load_val : rdata_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      err        <= 1'b0;
      rdata_hold <= 32'h0;
      load_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            idx_q   <= addr[AW+1:2];
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            lwlbu_q <= lwlbu;
            load_q  <= oeram && !rejected;
            if (rejected) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              err       <= 1'b1;
            end else if (oeram || swsb) begin
              state <= RD;
            end else begin
              state <= WR;
            end
          end
        end
        RD: begin
          if (load_q) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            err       <= 1'b0;
          end else begin
            state <= MRG;
          end
        end
        WR, MRG: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          err       <= 1'b0;
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          if (load_q) rdata_hold <= load_val;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array port kept free of reset so it maps onto block RAM; a reset on the
  // write edge suppresses the write.
  always_ff @(posedge clk) begin
    if (state == RD) rd_word <= mem[idx_q];
    if (!rst && state == WR)       mem[idx_q] <= wdata_q;
    else if (!rst && state == MRG) mem[idx_q] <= merged;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the internal data array (power of 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 SHALL have port req_valid, input, 1 bit: a memory request is presented.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request; high only in IDLE.
REQ-006 SHALL have port oeram, input, 1 bit: the request is a load (read).
REQ-007 SHALL have port weram, input, 1 bit: the request is a store (write).
REQ-008 SHALL have port lwlbu, input, 1 bit: load size; 0 = lw (word), 1 = lbu (byte, zero-extended).
REQ-009 SHALL have port swsb, input, 1 bit: store size; 0 = sw (word), 1 = sb (byte).
REQ-010 SHALL have port addr, input, 32 bits: byte address.
REQ-011 SHALL have port wdata, input, 32 bits: store data; sb uses wdata[7:0].
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse per accepted request.
REQ-013 SHALL have port rdata, output, 32 bits: load result.
REQ-014 SHALL have port err, output, 1 bit: the completing request was rejected; valid only while rsp_valid = 1.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid = 1, req_ready = 1, and (oeram or weram) = 1, latching addr, wdata, lwlbu, swsb, oeram and weram.
REQ-016 SHALL treat req_valid = 1 with oeram = weram = 0 as no request: nothing is accepted and the block stays in IDLE.
REQ-017 SHALL implement states IDLE, RD, WR, MRG and DONE.
REQ-018 SHALL take these state paths after an accepted request:
- load: IDLE -> RD -> DONE
- sw: IDLE -> WR -> DONE
- sb: IDLE -> RD -> MRG -> DONE
- rejected request: IDLE -> DONE
- DONE -> IDLE always.
REQ-019 SHALL assert rsp_valid only in DONE, for exactly one cycle, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-020 SHALL read the array synchronously: the word at index addr[log2(DEPTH_WORDS)+1:2] is read at the end of RD and is available in the following state.
REQ-021 SHALL, for lw, drive rdata with the read word in DONE.
REQ-022 SHALL, for lbu, drive rdata = {24'b0, byte lane addr[1:0]} in DONE, little-endian (lane 0 = bits 7:0).
REQ-023 SHALL hold rdata from one DONE to the next load's DONE; stores and rejected requests leave rdata unchanged.
REQ-024 SHALL, for sw, write wdata to the addressed word at the end of WR.
REQ-025 SHALL, for sb, replace only lane addr[1:0] of the word read in RD with wdata[7:0] and write the merged word at the end of MRG; the other three bytes SHALL be preserved.
REQ-026 SHALL reject the following requests, with no array write and rdata unchanged:
- oeram = weram = 1
- lw or sw with addr[1:0] != 0
- word index addr[31:2] >= DEPTH_WORDS
REQ-027 SHALL set err = 1 in DONE for a rejected request and err = 0 for every other request.
REQ-028 SHALL ignore changes on the request inputs while not in IDLE.

Reset
REQ-029 SHALL, on rst = 1 at a rising edge, force state IDLE, rsp_valid = 0, err = 0 and rdata = 0; req_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 SHALL, when rst arrives mid-operation, cancel the in-flight request: no rsp_valid, and no array write unless the write edge in WR or MRG has already occurred.
REQ-031 SHALL leave array contents unaffected by rst.

Verification
REQ-032 SHALL cover word round trip: sw addr 0x10, data 0xDEADBEEF, then lw addr 0x10 -> rdata = 0xDEADBEEF, err = 0, with rsp_valid two cycles after the load is accepted.
REQ-033 SHALL cover byte merge: after the 0xDEADBEEF store, sb addr 0x12, data 0x55 -> a later lw addr 0x10 returns 0xDE55BEEF; lbu addr 0x13 returns 0x000000DE.
REQ-034 SHALL cover a misaligned word store: sw addr 0x11 -> rsp_valid with err = 1; a later lw addr 0x10 is unchanged and err = 0.
REQ-035 SHALL cover an illegal and an out-of-range request: oeram = weram = 1 -> err = 1 one cycle after acceptance; lw addr 4*DEPTH_WORDS -> err = 1, rdata unchanged.
REQ-036 SHALL cover reset mid-operation: assert rst during RD of an sb to addr 0x20 -> no rsp_valid; word 0x20 is unchanged; req_ready = 1 in the cycle after reset is released.
REQ-037 SHALL cover the no-op and handshake cases:
- req_valid = 1 with oeram = weram = 0 -> no rsp_valid and state stays IDLE
- inputs toggled during a busy period do not alter the result.
